// File: rtl/io_bank_ctrl.sv
// Padring bank controller: per-pin config registers, a staggered side power-up
// sequencer, and gating of core pin controls onto the pad ring.
module io_bank_ctrl #(
    parameter  int NSIDES  = 4,
    parameter  int NPINS   = 9,
    parameter  int CFGW    = 18,
    parameter  int PWRUP   = 64,
    parameter  int STAGGER = 16,
    localparam int NP      = NSIDES * NPINS,
    localparam int AW      = $clog2(NP + 1)
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_write,
    input  logic [AW-1:0]        req_addr,
    input  logic [CFGW+3:0]      req_wdata,
    output logic                 rsp_valid,
    output logic [CFGW+3:0]      rsp_rdata,
    output logic                 rsp_err,
    input  logic [NP-1:0]        core_dout,
    input  logic [NP-1:0]        core_oen,
    input  logic [NP-1:0]        core_ie,
    output logic [NP-1:0]        pad_a,
    output logic [NP-1:0]        pad_oe,
    output logic [NP-1:0]        pad_ie,
    output logic [NP-1:0]        pad_pe,
    output logic [NP-1:0]        pad_ps,
    output logic [NP*CFGW-1:0]   pad_cfg,
    output logic [NSIDES-1:0]    side_en,
    output logic                 bank_ready
);

    localparam int DW   = CFGW + 4;
    localparam int CMAX = (PWRUP > STAGGER) ? PWRUP : STAGGER;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int SW   = $clog2(NSIDES + 1);
    localparam logic [AW-1:0] CTRL_ADDR = AW'(NP);
    localparam logic [DW-1:0] PIN_RST   = DW'(3);

    typedef enum logic [1:0] {
        ST_SAFE    = 2'd0,
        ST_STAGGER = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [SW-1:0]       side_q, side_d;
    logic [NSIDES-1:0]   side_en_q, side_en_d;
    logic [DW-1:0]       regs_q [NP];
    logic [DW-1:0]       regs_d [NP];
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [DW-1:0]       rsp_rdata_q, rsp_rdata_d;
    logic                accept;
    logic                quiesce;

    assign req_ready  = ~rsp_valid_q;
    assign accept     = req_valid & ~rsp_valid_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_err    = rsp_err_q;
    assign rsp_rdata  = rsp_rdata_q;
    assign side_en    = side_en_q;
    assign bank_ready = (state_q == ST_RUN);
    assign pad_a      = core_dout;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        side_d      = side_q;
        side_en_d   = side_en_q;
        regs_d      = regs_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        quiesce     = 1'b0;

        if (accept) begin
            rsp_valid_d = 1'b1;
            if (req_addr > CTRL_ADDR) begin
                rsp_err_d = 1'b1;
            end else if (req_addr == CTRL_ADDR) begin
                if (req_write) quiesce = req_wdata[0];
                else           rsp_rdata_d[2:0] = {state_q, bank_ready};
            end else begin
                for (int unsigned p = 0; p < NP; p++) begin
                    if (req_addr == AW'(p)) begin
                        if (req_write) regs_d[p] = req_wdata;
                        else           rsp_rdata_d = regs_q[p];
                    end
                end
            end
        end

        case (state_q)
            ST_SAFE: begin
                if (cnt_q == CW'(PWRUP - 1)) begin
                    cnt_d        = '0;
                    side_en_d[0] = 1'b1;
                    if (NSIDES == 1) begin
                        state_d = ST_RUN;
                    end else begin
                        state_d = ST_STAGGER;
                        side_d  = SW'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_STAGGER: begin
                if (cnt_q == CW'(STAGGER - 1)) begin
                    cnt_d = '0;
                    for (int unsigned s = 0; s < NSIDES; s++) begin
                        if (side_q == SW'(s)) side_en_d[s] = 1'b1;
                    end
                    if (side_q == SW'(NSIDES - 1)) state_d = ST_RUN;
                    else                           side_d  = side_q + SW'(1);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_RUN: begin
                side_en_d = '1;
            end
            default: begin
                state_d = ST_SAFE;
            end
        endcase

        // Quiesce overrides any sequencer progress made in the same cycle.
        if (quiesce) begin
            state_d   = ST_SAFE;
            cnt_d     = '0;
            side_d    = '0;
            side_en_d = '0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= ST_SAFE;
            cnt_q       <= '0;
            side_q      <= '0;
            side_en_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            for (int unsigned p = 0; p < NP; p++) regs_q[p] <= PIN_RST;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            side_q      <= side_d;
            side_en_q   <= side_en_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            for (int unsigned p = 0; p < NP; p++) regs_q[p] <= regs_d[p];
        end
    end

    for (genvar i = 0; i < NP; i++) begin : g_pin
        localparam int S = i / NPINS;
        assign pad_oe[i] = side_en_q[S] & ~core_oen[i] & regs_q[i][1];
        assign pad_ie[i] = side_en_q[S] & core_ie[i] & regs_q[i][0];
        assign pad_pe[i] = regs_q[i][2];
        assign pad_ps[i] = regs_q[i][3];
        assign pad_cfg[i*CFGW +: CFGW] = regs_q[i][4 +: CFGW];
    end

endmodule

// File: tb/tb_io_bank_ctrl.sv
// Self-checking bench for io_bank_ctrl: power-up timeline, register access via a
// response scoreboard, pin gating vectors, quiesce and asynchronous reset cases.
module tb_io_bank_ctrl;

    localparam int NS   = 4;
    localparam int NPN  = 9;
    localparam int NP   = 36;
    localparam int CFGW = 18;
    localparam int DW   = 22;
    localparam int AW   = 6;
    localparam int PWR  = 64;
    localparam int STG  = 16;

    logic              clk;
    logic              nreset;
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_wdata;
    logic              rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_err;
    logic [NP-1:0]     core_dout, core_oen, core_ie;
    logic [NP-1:0]     pad_a, pad_oe, pad_ie, pad_pe, pad_ps;
    logic [NP*CFGW-1:0] pad_cfg;
    logic [NS-1:0]     side_en;
    logic              bank_ready;

    io_bank_ctrl #(
        .NSIDES (NS),
        .NPINS  (NPN),
        .CFGW   (CFGW),
        .PWRUP  (PWR),
        .STAGGER(STG)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .core_dout (core_dout),
        .core_oen  (core_oen),
        .core_ie   (core_ie),
        .pad_a     (pad_a),
        .pad_oe    (pad_oe),
        .pad_ie    (pad_ie),
        .pad_pe    (pad_pe),
        .pad_ps    (pad_ps),
        .pad_cfg   (pad_cfg),
        .side_en   (side_en),
        .bank_ready(bank_ready)
    );

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [DW-1:0] rdata;
        logic          err;
    } rsp_t;
    rsp_t sbq[$];

    typedef struct {
        logic [NP-1:0] dout, oen, ie;
        logic [NP-1:0] ea, eoe, eie;
    } vec_t;
    vec_t tbl[5];

    logic [DW-1:0] model [NP];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h, required 'h%0h", name, act, exp);
        end
    endtask

    function automatic logic [NS-1:0] side_exp(input int k);
        int n;
        logic [NS-1:0] r;
        n = (k < PWR) ? 0 : 1 + (k - PWR) / STG;
        if (n > NS) n = NS;
        r = '0;
        for (int s = 0; s < n; s++) r[s] = 1'b1;
        return r;
    endfunction

    function automatic logic [NP-1:0] exp_oe(input logic [NS-1:0] se);
        logic [NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i] = se[i / NPN] & ~core_oen[i] & model[i][1];
        return r;
    endfunction

    function automatic logic [NP-1:0] exp_ie(input logic [NS-1:0] se);
        logic [NP-1:0] r;
        for (int i = 0; i < NP; i++) r[i] = se[i / NPN] & core_ie[i] & model[i][0];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NP; i++) model[i] = DW'(3);
    endtask

    task automatic check_regs(input string tag);
        logic [NP-1:0]      pe, ps;
        logic [NP*CFGW-1:0] cfg;
        for (int i = 0; i < NP; i++) begin
            pe[i] = model[i][2];
            ps[i] = model[i][3];
            cfg[i*CFGW +: CFGW] = model[i][4 +: CFGW];
        end
        chk({tag, "_pad_pe"}, pad_pe, pe);
        chk({tag, "_pad_ps"}, pad_ps, ps);
        chk({tag, "_pad_cfg"}, pad_cfg, cfg);
    endtask

    // Response scoreboard: every rsp_valid must match the oldest queued expectation.
    always @(negedge clk) begin : mon
        rsp_t e;
        if (nreset && rsp_valid) begin
            if (sbq.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL rsp_unexpected: got rsp_valid=1, required no response");
            end else begin
                e = sbq.pop_front();
                chk("rsp_rdata", rsp_rdata, e.rdata);
                chk("rsp_err", rsp_err, e.err);
            end
        end
    end

    task automatic req(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [DW-1:0] ctrl_exp);
        rsp_t e;
        int   n;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        n = 0;
        while (!req_ready && n < 4) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            tests++;
            fails++;
            $display("FAIL req_ready_timeout: got req_ready=0, required 1");
            req_valid = 1'b0;
        end else begin
            e.err   = (a > AW'(NP));
            e.rdata = '0;
            if (!w && a == AW'(NP)) begin
                e.rdata = ctrl_exp;
            end else if (a < AW'(NP)) begin
                if (w) model[a] = d;
                else   e.rdata = model[a];
            end
            sbq.push_back(e);
            @(posedge clk);
            #1 req_valid = 1'b0;
        end
    endtask

    // Starts with the sequencer in SAFE and its counter at zero.
    task automatic run_powerup(input string tag);
        logic [NS-1:0] se;
        for (int k = 1; k <= PWR + NS * STG; k++) begin
            @(posedge clk);
            @(negedge clk);
            se = side_exp(k);
            chk({tag, "_side_en"}, side_en, se);
            chk({tag, "_bank_ready"}, bank_ready, (k >= PWR + (NS - 1) * STG));
            chk({tag, "_pad_oe"}, pad_oe, exp_oe(se));
            chk({tag, "_pad_ie"}, pad_ie, exp_ie(se));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no completion, required $finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{dout: '0, oen: '0, ie: '0, ea: '0, eoe: '1, eie: '0};
        tbl[1] = '{dout: '1, oen: '1, ie: '1, ea: '1, eoe: '0, eie: '1};
        tbl[2] = '{dout: 36'hA5A5A5A5A, oen: 36'h5A5A5A5A5, ie: 36'hF0F0F0F0F,
                   ea: 36'hA5A5A5A5A, eoe: 36'hA5A5A5A5A, eie: 36'hF0F0F0F0F};
        tbl[3] = '{dout: 36'h123456789, oen: 36'hFEDCBA987, ie: 36'h0F0F0F0F0,
                   ea: 36'h123456789, eoe: 36'h012345678, eie: 36'h0F0F0F0F0};
        tbl[4].dout = {$urandom_range(15, 0), $urandom()};
        tbl[4].oen  = {$urandom_range(15, 0), $urandom()};
        tbl[4].ie   = {$urandom_range(15, 0), $urandom()};
        tbl[4].ea   = tbl[4].dout;
        tbl[4].eoe  = ~tbl[4].oen;
        tbl[4].eie  = tbl[4].ie;

        nreset    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        core_dout = '0;
        core_oen  = '0;
        core_ie   = '1;
        model_reset();
        #2 nreset = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_side_en", side_en, 0);
        chk("rst_bank_ready", bank_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_pad_oe", pad_oe, 0);
        check_regs("rst");

        nreset = 1'b1;
        run_powerup("pwrup");

        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            core_dout = tbl[v].dout;
            core_oen  = tbl[v].oen;
            core_ie   = tbl[v].ie;
            #1;
            chk($sformatf("vec%0d_pad_a", v), pad_a, tbl[v].ea);
            chk($sformatf("vec%0d_pad_oe", v), pad_oe, tbl[v].eoe);
            chk($sformatf("vec%0d_pad_ie", v), pad_ie, tbl[v].eie);
        end
        core_dout = '0;
        core_oen  = '0;
        core_ie   = '1;

        req(1'b1, 6'd12, 22'h2A5, '0);
        chk("wr12_pad_pe", pad_pe[12], 1);
        chk("wr12_pad_ps", pad_ps[12], 0);
        chk("wr12_pad_cfg", pad_cfg[12*CFGW +: CFGW], 18'h2A);
        chk("wr12_pad_oe", pad_oe[12], 0);
        req(1'b0, 6'd12, '0, '0);

        req(1'b1, 6'd5, 22'h1, '0);
        chk("mask5_side0_oe", pad_oe[8:0], 9'h1DF);
        chk("mask5_all_oe", pad_oe, exp_oe('1));

        req(1'b0, 6'd36, '0, 22'd5);
        req(1'b0, 6'd40, '0, '0);
        req(1'b1, 6'd40, '1, '0);
        req(1'b1, 6'd36, 22'h2, '0);
        @(negedge clk);
        chk("ctrl_nop_bank_ready", bank_ready, 1);
        check_regs("badaddr");

        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 6'd3;
        for (int j = 0; j < 6; j++) begin
            if (j > 0) @(negedge clk);
            chk($sformatf("b2b_ready%0d", j), req_ready, (j % 2 == 0));
            if (j % 2 == 0) sbq.push_back('{rdata: model[3], err: 1'b0});
        end
        @(posedge clk);
        #1 req_valid = 1'b0;

        req(1'b1, 6'd36, 22'h1, '0);
        chk("quiesce_side_en", side_en, 0);
        chk("quiesce_bank_ready", bank_ready, 0);
        run_powerup("requiesce_run");

        req(1'b1, 6'd36, 22'h1, '0);
        repeat (PWR + 4) @(posedge clk);
        req(1'b0, 6'd36, '0, 22'd2);

        repeat (2) @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 6'd12;
        @(posedge clk);
        #1;
        nreset    = 1'b0;
        req_valid = 1'b0;
        model_reset();
        #1;
        chk("async_rsp_valid", rsp_valid, 0);
        chk("async_rsp_rdata", rsp_rdata, 0);
        chk("async_rsp_err", rsp_err, 0);
        chk("async_side_en", side_en, 0);
        chk("async_bank_ready", bank_ready, 0);
        chk("async_pad_oe", pad_oe, 0);
        chk("async_pad_ie", pad_ie, 0);
        check_regs("async");
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("async_no_rsp", rsp_valid, 0);
        end
        nreset = 1'b1;

        repeat (30) @(posedge clk);
        req(1'b1, 6'd36, 22'h1, '0);
        chk("safe_quiesce_side_en", side_en, 0);
        run_powerup("safe_quiesce");

        repeat (2) @(negedge clk);
        chk("sb_empty", sbq.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
